// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, issue and clear-control bundle of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_dat_o;
  logic [NUM_RD-1:0]      rd_pend_o;
  logic                   wr0_en_i;
  logic [AW-1:0]          wr0_addr_i;
  logic [XLEN-1:0]        wr0_dat_i;
  logic                   wr1_en_i;
  logic [AW-1:0]          wr1_addr_i;
  logic [XLEN-1:0]        wr1_dat_i;
  logic                   iss_vld_i;
  logic [AW-1:0]          iss_addr_i;
  logic                   clr_req_i;
  logic                   busy_o;
  logic                   clr_done_o;
  modport master (
    output rd_addr_i, wr0_en_i, wr0_addr_i, wr0_dat_i, wr1_en_i, wr1_addr_i, wr1_dat_i,
           iss_vld_i, iss_addr_i, clr_req_i,
    input  rd_dat_o, rd_pend_o, busy_o, clr_done_o
  );
  modport slave (
    input  rd_addr_i, wr0_en_i, wr0_addr_i, wr0_dat_i, wr1_en_i, wr1_addr_i, wr1_dat_i,
           iss_vld_i, iss_addr_i, clr_req_i,
    output rd_dat_o, rd_pend_o, busy_o, clr_done_o
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: dual-write multi-read register file with bypass, pending scoreboard and clear sequencer
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam bit BYP = BYPASS != 0;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]       pend_q, pend_d;
  logic [AW-1:0]          ra [NUM_RD];
  logic [NUM_RD*XLEN-1:0] rd_dat;
  logic [NUM_RD-1:0]      rd_pend;
  logic                   idle, w0, w1, iss, clr_go;
  assign idle   = state_q == IDLE;
  assign w0     = idle && bus.wr0_en_i && bus.wr0_addr_i != '0;
  assign w1     = idle && bus.wr1_en_i && bus.wr1_addr_i != '0;
  assign iss    = idle && bus.iss_vld_i && bus.iss_addr_i != '0;
  assign clr_go = idle && bus.clr_req_i;
  always_comb begin
    state_d = clr_go ? CLEAR
            : (state_q == CLEAR && cnt_q == AW'(DEPTH - 1)) ? DONE
            : state_q == DONE ? IDLE : state_q;
    cnt_d   = clr_go ? AW'(1) : state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
    pend_d  = pend_q;
    for (int i = 0; i < DEPTH; i++)
      pend_d[i] = clr_go ? 1'b0
                : (iss && bus.iss_addr_i == AW'(i)) ? 1'b1
                : ((w0 && bus.wr0_addr_i == AW'(i)) || (w1 && bus.wr1_addr_i == AW'(i))) ? 1'b0
                : pend_q[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 1; i < DEPTH; i++)
        if (state_q == CLEAR && cnt_q == AW'(i)) mem_q[i] <= '0;
        else if (w1 && bus.wr1_addr_i == AW'(i)) mem_q[i] <= bus.wr1_dat_i;
        else if (w0 && bus.wr0_addr_i == AW'(i)) mem_q[i] <= bus.wr0_dat_i;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign ra[k] = bus.rd_addr_i[k*AW +: AW];
  end
  // w0/w1 already exclude address 0 and non-IDLE states, so bypass is suppressed while clearing
  always_comb begin
    rd_dat  = '0;
    rd_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_dat[k*XLEN +: XLEN] = ra[k] == '0 ? '0
                             : (BYP && w1 && bus.wr1_addr_i == ra[k]) ? bus.wr1_dat_i
                             : (BYP && w0 && bus.wr0_addr_i == ra[k]) ? bus.wr0_dat_i
                             : mem_q[ra[k]];
      rd_pend[k] = pend_q[ra[k]];
    end
  end
  assign bus.rd_dat_o   = rd_dat;
  assign bus.rd_pend_o  = rd_pend;
  assign bus.busy_o     = state_q == CLEAR;
  assign bus.clr_done_o = state_q == DONE;
endmodule
